// File: rtl/gon_sched_pkg.sv
// Shared types and constants for the GON scheduler: FSM state encoding and
// the reserved all-ones tag value that matches no PE.
package gon_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CFG_X,
    CFG_Y,
    DRAIN,
    DONE
  } gon_state_t;

  // Sliced down to XID_BITS / YID_BITS by the user.
  localparam logic [31:0] IDLE_TAG_X = 32'hFFFF_FFFF;
  localparam logic [31:0] IDLE_TAG_Y = 32'hFFFF_FFFF;

endpackage

// File: rtl/gon_id_scanner.sv
// Shift-count and scan-data generation for the X and Y ID chains. Counters
// are held at their start values whenever their phase is inactive.
module gon_id_scanner #(
  parameter int ROWS     = 6,
  parameter int COLS     = 8,
  parameter int XID_BITS = 3,
  parameter int YID_BITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_x,
  input  logic                cfg_y,
  output logic                set_xid,
  output logic [XID_BITS-1:0] xid_data,
  output logic                x_last,
  output logic                set_yid,
  output logic [YID_BITS-1:0] yid_data,
  output logic                y_last
);

  localparam int NX  = ROWS * COLS;
  localparam int XCW = (NX > 1) ? $clog2(NX) : 1;

  logic [XCW-1:0]      xcnt;
  logic [XID_BITS-1:0] xval;
  logic [YID_BITS-1:0] ycnt;

  // xval tracks (NX-1-k) mod COLS as a wrapping down-counter, avoiding a divider.
  always_ff @(posedge clk) begin
    if (!rst || !cfg_x) begin
      xcnt <= '0;
      xval <= XID_BITS'(COLS - 1);
    end else begin
      xcnt <= xcnt + 1'b1;
      xval <= (xval == '0) ? XID_BITS'(COLS - 1) : xval - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || !cfg_y) ycnt <= '0;
    else                ycnt <= ycnt + 1'b1;
  end

  assign set_xid  = cfg_x;
  assign xid_data = cfg_x ? xval : '0;
  assign x_last   = cfg_x && (xcnt == XCW'(NX - 1));

  assign set_yid  = cfg_y;
  assign yid_data = cfg_y ? (YID_BITS'(ROWS - 1) - ycnt) : '0;
  assign y_last   = cfg_y && (ycnt == YID_BITS'(ROWS - 1));

endmodule

// File: rtl/gon_scheduler.sv
// GON controller: configures PE X/Y ID chains, then drains every active PE in
// row-major order, writing each accepted beat to consecutive GLB addresses.
module gon_scheduler
  import gon_sched_pkg::*;
#(
  parameter int ROWS      = 6,
  parameter int COLS      = 8,
  parameter int XID_BITS  = 3,
  parameter int YID_BITS  = 3,
  parameter int CNT_BITS  = 8,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 drain_start,
  input  logic [YID_BITS-1:0]  rows_m1,
  input  logic [XID_BITS-1:0]  cols_m1,
  input  logic [CNT_BITS-1:0]  words_m1,
  input  logic [ADDR_BITS-1:0] base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 set_XID,
  output logic [XID_BITS-1:0]  XID_scan_in,
  output logic                 set_YID,
  output logic [YID_BITS-1:0]  YID_scan_in,
  output logic [XID_BITS-1:0]  tag_X,
  output logic [YID_BITS-1:0]  tag_Y,
  input  logic                 GON_valid,
  input  logic                 GON_ready,
  output logic                 glb_we,
  output logic [ADDR_BITS-1:0] glb_addr
);

  gon_state_t state, state_nxt;

  logic [YID_BITS-1:0]  row, rows_q;
  logic [XID_BITS-1:0]  col, cols_q;
  logic [CNT_BITS-1:0]  word, words_q;
  logic [ADDR_BITS-1:0] addr;
  logic                 beat, last_word, last_col, last_row;
  logic                 x_last, y_last;

  gon_id_scanner #(
    .ROWS(ROWS), .COLS(COLS), .XID_BITS(XID_BITS), .YID_BITS(YID_BITS)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .cfg_x   (state == CFG_X),
    .cfg_y   (state == CFG_Y),
    .set_xid (set_XID),
    .xid_data(XID_scan_in),
    .x_last  (x_last),
    .set_yid (set_YID),
    .yid_data(YID_scan_in),
    .y_last  (y_last)
  );

  assign beat      = GON_valid & GON_ready & (state == DRAIN);
  assign last_word = (word == words_q);
  assign last_col  = (col == cols_q);
  assign last_row  = (row == rows_q);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start)        state_nxt = CFG_X;
               else if (drain_start) state_nxt = DRAIN;
      CFG_X:   if (x_last)           state_nxt = CFG_Y;
      CFG_Y:   if (y_last)           state_nxt = DONE;
      DRAIN:   if (beat && last_word && last_col && last_row) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bounds are latched at start so the caller may change them mid-drain.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row     <= '0;
      col     <= '0;
      word    <= '0;
      addr    <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      words_q <= '0;
    end else if (state == IDLE && drain_start && !cfg_start) begin
      row     <= '0;
      col     <= '0;
      word    <= '0;
      addr    <= base_addr;
      rows_q  <= rows_m1;
      cols_q  <= cols_m1;
      words_q <= words_m1;
    end else if (beat) begin
      addr <= addr + 1'b1;
      if (last_word) begin
        word <= '0;
        if (last_col) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        word <= word + 1'b1;
      end
    end
  end

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign tag_X    = (state == DRAIN) ? col : IDLE_TAG_X[XID_BITS-1:0];
  assign tag_Y    = (state == DRAIN) ? row : IDLE_TAG_Y[YID_BITS-1:0];
  assign glb_we   = beat;
  assign glb_addr = addr;

endmodule
